// File: rtl/dp_issue_ctrl.sv
// dp_issue_ctrl: issue/writeback stage for an external barrel shifter + ALU.
// Accepts one ARM data-processing word per handshake, reads its operands from an
// internal 16x32 register file, drives the shifter/ALU inputs for EXEC_CYCLES
// cycles, then writes the ALU result F back to Rd (compares/tests excepted).
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_instr   instruction handshake input (cond field ignored)
//   in_ready            high only while idle
//   ld_en/addr/data     register-file preload, honoured only while idle
//   dbg_addr/dbg_data   combinational register-file read
//   alu_s               flag-update enable, final EXEC cycle only
//   shift_data/num/op   operand-2 shifter controls
//   alu_a, alu_op       ALU operand A and opcode
//   alu_f               ALU result, captured in the writeback cycle
//   done / err          one-cycle pulses: retired / non-DP word rejected
module dp_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        alu_s,
  output logic [31:0] shift_data,
  output logic [7:0]  shift_num,
  output logic [2:0]  shift_op,
  output logic [31:0] alu_a,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_f,
  output logic        done,
  output logic        err
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWb, StErr} state_e;

  state_e            state_q, state_d;
  logic [27:0]       instr_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       regs_q [16];

  logic [31:0]       shift_data_d;
  logic [7:0]        shift_num_d;
  logic [2:0]        shift_op_d;
  logic [31:0]       rm_val, rs_val;

  logic accept;
  logic exec_last;
  logic is_test;

  // Condition field plays no part in issue.
  logic unused_cond;
  assign unused_cond = ^in_instr[31:28];

  assign accept    = in_valid && (state_q == StIdle);
  assign exec_last = (cnt_q == CntW'(EXEC_CYCLES - 1));
  // TST/TEQ/CMP/CMN (1000..1011) only update flags.
  assign is_test   = (alu_op[3:2] == 2'b10);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= in_instr[27:0];
      if (state_q == StRead)      cnt_q <= '0;
      else if (state_q == StExec) cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StRead;
      StRead: state_d = (instr_q[27:26] != 2'b00) ? StErr : StExec;
      StExec: if (exec_last) state_d = StWb;
      StWb:   state_d = StIdle;
      StErr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = (state_q == StIdle);
    done     = (state_q == StWb);
    err      = (state_q == StErr);
    alu_s    = (state_q == StExec) && exec_last && instr_q[20];
  end

  // Operand-2 mapping, evaluated while in READ.
  assign rm_val = regs_q[instr_q[3:0]];
  assign rs_val = regs_q[instr_q[11:8]];

  always_comb begin
    shift_data_d = rm_val;
    shift_num_d  = {3'b000, instr_q[11:7]};
    shift_op_d   = {instr_q[6:5], 1'b0};
    if (instr_q[25]) begin
      // Immediate: 8-bit value rotated right by twice the 4-bit field.
      shift_data_d = {24'b0, instr_q[7:0]};
      shift_num_d  = {3'b000, instr_q[11:8], 1'b0};
      shift_op_d   = 3'b111;
    end else if (instr_q[4]) begin
      shift_num_d = rs_val[7:0];
      shift_op_d  = {instr_q[6:5], 1'b1};
    end
  end

  // ALU-side operand registers: loaded on READ->EXEC, cleared on return to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_data <= '0;
      shift_num  <= '0;
      shift_op   <= '0;
      alu_a      <= '0;
      alu_op     <= '0;
    end else if (state_q == StRead && state_d == StExec) begin
      shift_data <= shift_data_d;
      shift_num  <= shift_num_d;
      shift_op   <= shift_op_d;
      alu_a      <= regs_q[instr_q[19:16]];
      alu_op     <= instr_q[24:21];
    end else if (state_q != StIdle && state_d == StIdle) begin
      shift_data <= '0;
      shift_num  <= '0;
      shift_op   <= '0;
      alu_a      <= '0;
      alu_op     <= '0;
    end
  end

  // Register file. Preload and writeback live in different states, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (state_q == StIdle && ld_en) begin
      regs_q[ld_addr] <= ld_data;
    end else if (state_q == StWb && !is_test) begin
      regs_q[instr_q[15:12]] <= alu_f;
    end
  end

  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_dp_issue_ctrl.sv
module tb_dp_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  dbg_addr;
  logic        sel;   // 0: EXEC_CYCLES=1 instance, 1: EXEC_CYCLES=3 instance

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- external shifter/ALU model (carry-in treated as 0) ----------------
  function automatic logic [31:0] barrel(input logic [31:0] d, input logic [1:0] t,
                                         input logic [7:0] n);
    logic signed [31:0] sd;
    sd = d;
    case (t)
      2'd0:    return (n >= 8'd32) ? 32'd0 : d << n;
      2'd1:    return (n >= 8'd32) ? 32'd0 : d >> n;
      2'd2:    return (n >= 8'd32) ? {32{d[31]}} : 32'(sd >>> n);
      default: return (d >> n[4:0]) | (d << (6'd32 - {1'b0, n[4:0]}));
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a ^ b;
      4'h2: return a - b;
      4'h3: return b - a;
      4'h4: return a + b;
      4'h5: return a + b;
      4'h6: return a - b - 32'd1;
      4'h7: return b - a - 32'd1;
      4'h8: return a & b;
      4'h9: return a ^ b;
      4'hA: return a - b;
      4'hB: return a + b;
      4'hC: return a | b;
      4'hD: return b;
      4'hE: return a & ~b;
      default: return ~b;
    endcase
  endfunction

  // ---------------- two DUT instances ----------------
  logic        rdy1, rdy3, s1, s3, done1, done3, err1, err3;
  logic [31:0] dbg1, dbg3, sd1, sd3, a1, a3, f1, f3;
  logic [7:0]  sn1, sn3;
  logic [2:0]  so1, so3;
  logic [3:0]  op1, op3;

  assign f1 = alu_fn(op1, a1, barrel(sd1, so1[2:1], sn1));
  assign f3 = alu_fn(op3, a3, barrel(sd3, so3[2:1], sn3));

  dp_issue_ctrl #(.EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_instr(in_instr), .in_ready(rdy1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg1), .alu_s(s1), .shift_data(sd1), .shift_num(sn1), .shift_op(so1),
    .alu_a(a1), .alu_op(op1), .alu_f(f1), .done(done1), .err(err1)
  );

  dp_issue_ctrl #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_instr(in_instr), .in_ready(rdy3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg3), .alu_s(s3), .shift_data(sd3), .shift_num(sn3), .shift_op(so3),
    .alu_a(a3), .alu_op(op3), .alu_f(f3), .done(done3), .err(err3)
  );

  logic        m_ready, m_s, m_done, m_err;
  logic [31:0] m_dbg, m_sd, m_a;
  logic [7:0]  m_sn;
  logic [2:0]  m_so;
  logic [3:0]  m_op;
  int          ex;

  assign m_ready = sel ? rdy3  : rdy1;
  assign m_s     = sel ? s3    : s1;
  assign m_done  = sel ? done3 : done1;
  assign m_err   = sel ? err3  : err1;
  assign m_dbg   = sel ? dbg3  : dbg1;
  assign m_sd    = sel ? sd3   : sd1;
  assign m_a     = sel ? a3    : a1;
  assign m_sn    = sel ? sn3   : sn1;
  assign m_so    = sel ? so3   : so1;
  assign m_op    = sel ? op3   : op1;
  assign ex      = sel ? 3 : 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          is_err;
    int          acc;
    bit          s;
    logic [31:0] a, sd;
    logic [7:0]  sn;
    logic [2:0]  so;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [16];

  // Architectural effect of one instruction on the model register file.
  function automatic exp_t model_issue(input logic [31:0] ins, input int acc);
    exp_t        e;
    logic [31:0] rn, rm, rs, op2, res;
    logic [63:0] dbl;
    int          amt;
    e.acc = acc; e.is_err = (ins[27:26] != 2'b00); e.s = 1'b0;
    e.a = 0; e.sd = 0; e.sn = 0; e.so = 0; e.op = 0;
    if (e.is_err) return e;
    rn = mregs[ins[19:16]]; rm = mregs[ins[3:0]]; rs = mregs[ins[11:8]];
    e.s = ins[20]; e.a = rn; e.op = ins[24:21];
    if (ins[25]) begin
      amt = 2 * int'(ins[11:8]);
      dbl = {24'b0, ins[7:0], 24'b0, ins[7:0]} >> amt;
      op2 = dbl[31:0];
      e.sd = {24'b0, ins[7:0]}; e.sn = 8'(amt); e.so = 3'b111;
    end else begin
      e.sd = rm;
      e.sn = ins[4] ? rs[7:0] : {3'b0, ins[11:7]};
      e.so = {ins[6:5], ins[4]};
      op2  = barrel(rm, ins[6:5], e.sn);
    end
    res = alu_fn(ins[24:21], rn, op2);
    if (ins[24:23] != 2'b10) mregs[ins[15:12]] = res;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int s_cnt = 0;
  bit chk_ready = 0;

  always @(negedge clk) begin
    exp_t it;
    if (rst) begin
      s_cnt = 0;
      chk_ready = 0;
    end else begin
      if (chk_ready) begin
        chk(m_ready, "ready_after_retire", 32'(m_ready), 32'd1);
        chk_ready = 0;
      end
      if (m_s) begin
        s_cnt++;
        if (sb.size() != 0) chk(cyc - sb[0].acc == 1 + ex, "alu_s_timing",
                                32'(cyc - sb[0].acc), 32'(1 + ex));
      end
      if (m_done || m_err) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_done_err", {30'b0, m_done, m_err}, 32'd0);
        end else begin
          it = sb.pop_front();
          chk(m_err == it.is_err, "kind_err", 32'(m_err), 32'(it.is_err));
          chk(m_done != it.is_err, "kind_done", 32'(m_done), 32'(!it.is_err));
          if (it.is_err) begin
            chk(cyc - it.acc == 2, "err_latency", 32'(cyc - it.acc), 32'd2);
            chk(m_a == 0 && m_sd == 0 && m_op == 0, "err_bus_zero", m_a | m_sd, 32'd0);
          end else begin
            chk(cyc - it.acc == 2 + ex, "done_latency", 32'(cyc - it.acc), 32'(2 + ex));
            chk(m_a == it.a, "alu_a", m_a, it.a);
            chk(m_sd == it.sd, "shift_data", m_sd, it.sd);
            chk(m_sn == it.sn, "shift_num", 32'(m_sn), 32'(it.sn));
            chk(m_so == it.so, "shift_op", 32'(m_so), 32'(it.so));
            chk(m_op == it.op, "alu_op", 32'(m_op), 32'(it.op));
          end
          chk(s_cnt == int'(it.s), "alu_s_pulses", 32'(s_cnt), 32'(it.s));
          s_cnt = 0;
          chk_ready = 1;
        end
      end else if (m_ready) begin
        chk(m_a == 0 && m_sd == 0 && m_sn == 0 && m_so == 0 && m_op == 0 && !m_s,
            "idle_outputs_zero", m_a | m_sd | 32'(m_sn) | 32'(m_so) | 32'(m_op), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) chk(1'b0, "wait_ready_timeout", 32'(n), 32'd100);
  endtask

  task automatic wait_quiet();
    int n = 0;
    wait_idle();
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk(1'b0, "scoreboard_drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic load(input logic [3:0] r, input logic [31:0] v);
    wait_idle();
    ld_en = 1; ld_addr = r; ld_data = v; mregs[r] = v;
    @(posedge clk); #1;
    ld_en = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input bit ld, input logic [3:0] lr,
                       input logic [31:0] lv);
    wait_idle();
    if (ld) begin
      ld_en = 1; ld_addr = lr; ld_data = lv; mregs[lr] = lv;
    end
    in_valid = 1; in_instr = ins;
    sb.push_back(model_issue(ins, cyc));
    @(posedge clk); #1;
    in_valid = 0; ld_en = 0;
  endtask

  task automatic chk_reg(input logic [3:0] r, input logic [31:0] v, input string name);
    dbg_addr = r; #1;
    chk(m_dbg == v, name, m_dbg, v);
  endtask

  task automatic sweep();
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r); #1;
      chk(m_dbg == mregs[r], $sformatf("reg_r%0d", r), m_dbg, mregs[r]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    sb.delete();
    for (int r = 0; r < 16; r++) mregs[r] = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic random_run(input int n);
    logic [31:0] ins;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) load(4'($urandom_range(0, 15)), $urandom);
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[27:26] = 2'b00;
      issue(ins, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), $urandom);
    end
    wait_quiet();
  endtask

  initial begin
    rst = 1; sel = 0; in_valid = 0; in_instr = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
    for (int r = 0; r < 16; r++) mregs[r] = 0;
    repeat (2) @(negedge clk);
    chk(m_ready && !m_done && !m_err && m_a == 0 && m_sd == 0, "reset_state",
        {m_ready, m_done, m_err, 29'(m_a | m_sd)}, 32'h8000_0000);
    rst = 0;
    @(negedge clk);
    sweep();

    // ADD R0,R1,R2
    load(4'd1, 32'd5); load(4'd2, 32'd3);
    issue(32'hE0810002, 0, 0, 0);
    wait_quiet();
    chk_reg(4'd0, 32'd8, "add_r0");

    // MOV R3,#0xFF ror 8
    issue(32'hE3A034FF, 0, 0, 0);
    wait_quiet();
    chk_reg(4'd3, 32'hFF00_0000, "mov_imm_r3");

    // ADD R4,R1,R2,LSL R5
    load(4'd5, 32'd2);
    issue(32'hE0814512, 0, 0, 0);
    wait_quiet();
    chk_reg(4'd4, 32'd17, "add_lsl_reg_r4");

    // CMP R1,R2 with S: no writeback
    issue(32'hE1510002, 0, 0, 0);
    wait_quiet();
    sweep();

    // LDR: rejected
    issue(32'hE5912000, 0, 0, 0);
    wait_quiet();
    sweep();

    // Preload in the accept cycle is seen by READ
    issue(32'hE0810002, 1, 4'd1, 32'd100);
    wait_quiet();
    chk_reg(4'd0, 32'd103, "ld_with_accept_r0");

    // Reset during EXEC abandons the instruction
    load(4'd1, 32'd5); load(4'd2, 32'd3); load(4'd0, 32'd0);
    issue(32'hE0810002, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    sb.delete();
    for (int r = 0; r < 16; r++) mregs[r] = 0;
    #1;
    chk(m_ready && !m_done && !m_s && m_a == 0 && m_sd == 0 && m_op == 0 && m_sn == 0,
        "reset_mid_exec", {m_ready, m_done, m_s, 29'(m_a | m_sd)}, 32'h8000_0000);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    sweep();

    random_run(40);
    sweep();

    // EXEC_CYCLES=3 instance
    do_reset();
    sel = 1;
    load(4'd1, 32'd5); load(4'd2, 32'd3);
    issue(32'hE0810002, 0, 0, 0);
    wait_quiet();
    chk_reg(4'd0, 32'd8, "add_r0_exec3");
    issue(32'hE1510002, 0, 0, 0);
    random_run(15);
    sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d checks required completion", checks);
    $fatal(1);
  end

endmodule
